// File: rtl/branch_history_predictor.sv
// Tagged direct-mapped branch predictor with saturating counters and ID-stage recovery.
// Optional gshare indexing (GHR XOR PC index) is enabled by defining BP_GSHARE_EN.
module branch_history_predictor #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned CNT_BITS   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] fetchPC,
    output logic                predTaken,
    output logic [PC_WIDTH-1:0] predTarget,
    input  logic                resValid,
    input  logic [PC_WIDTH-1:0] resPC,
    input  logic [5:0]          opCode,
    input  logic                compResult,
    input  logic [PC_WIDTH-1:0] resTarget,
    input  logic                resPredTaken,
    input  logic                stall,
    output logic                PCSrcS,
    output logic                FlushS,
    output logic [PC_WIDTH-1:0] recoverPC
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W   = PC_WIDTH - INDEX_BITS - 2;

    localparam logic [CNT_BITS-1:0] CNT_WT  = {1'b1, {(CNT_BITS-1){1'b0}}};
    localparam logic [CNT_BITS-1:0] CNT_WNT = {1'b0, {(CNT_BITS-1){1'b1}}};

    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5;

    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

    logic [INDEX_BITS-1:0] fetch_idx;
    logic [INDEX_BITS-1:0] res_idx;
    logic [TAG_W-1:0]      fetch_tag;
    logic [TAG_W-1:0]      res_tag;

`ifdef BP_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_q;

    always_comb begin
        fetch_idx = fetchPC[INDEX_BITS+1:2] ^ ghr_q;
        res_idx   = resPC[INDEX_BITS+1:2] ^ ghr_q;
    end
`else
    always_comb begin
        fetch_idx = fetchPC[INDEX_BITS+1:2];
        res_idx   = resPC[INDEX_BITS+1:2];
    end
`endif

    always_comb begin
        fetch_tag = fetchPC[PC_WIDTH-1:INDEX_BITS+2];
        res_tag   = resPC[PC_WIDTH-1:INDEX_BITS+2];
    end

    // Lookup reads registered contents only, so a same-cycle update is not bypassed.
    always_comb begin
        predTaken  = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag)
                     && cnt_q[fetch_idx][CNT_BITS-1];
        predTarget = predTaken ? target_q[fetch_idx] : fetchPC + PC_WIDTH'(4);
    end

    logic is_branch;
    logic actual_taken;
    logic mispredict;
    logic do_update;
    logic res_hit;
    logic [CNT_BITS-1:0] next_cnt;
    logic [PC_WIDTH-1:0] next_target;

    always_comb begin
        is_branch    = 1'b0;
        actual_taken = 1'b0;
        case (opCode)
            OP_J: begin
                is_branch    = 1'b1;
                actual_taken = 1'b1;
            end
            OP_BEQ: begin
                is_branch    = 1'b1;
                actual_taken = compResult;
            end
            OP_BNE: begin
                is_branch    = 1'b1;
                actual_taken = ~compResult;
            end
            default: ;
        endcase
    end

    always_comb begin
        mispredict = resValid & is_branch & (actual_taken != resPredTaken);
        PCSrcS     = mispredict;
        FlushS     = mispredict;
        recoverPC  = actual_taken ? resTarget : resPC + PC_WIDTH'(4);
        do_update  = resValid & ~stall & is_branch;
        res_hit    = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
    end

    // Jumps pin the counter high; a miss allocates at the weak state matching the outcome.
    always_comb begin
        next_cnt = cnt_q[res_idx];
        if (opCode == OP_J) begin
            next_cnt = '1;
        end else if (!res_hit) begin
            next_cnt = actual_taken ? CNT_WT : CNT_WNT;
        end else if (actual_taken) begin
            if (next_cnt != '1) next_cnt = next_cnt + CNT_BITS'(1);
        end else begin
            if (next_cnt != '0) next_cnt = next_cnt - CNT_BITS'(1);
        end
        next_target = (!res_hit || actual_taken) ? resTarget : target_q[res_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '{default: 1'b0};
            tag_q    <= '{default: '0};
            target_q <= '{default: '0};
            cnt_q    <= '{default: CNT_WNT};
`ifdef BP_GSHARE_EN
            ghr_q    <= '0;
`endif
        end else if (do_update) begin
            valid_q[res_idx]  <= 1'b1;
            tag_q[res_idx]    <= res_tag;
            target_q[res_idx] <= next_target;
            cnt_q[res_idx]    <= next_cnt;
`ifdef BP_GSHARE_EN
            ghr_q             <= (ghr_q << 1) | INDEX_BITS'(actual_taken);
`endif
        end
    end

endmodule
